tenkey_scan: RTL and testbench
==============================

TENKEY_SCAN -- requirements
Module: tenkey_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each row is driven; legal range 3..255.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive agreeing samples needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port ck, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port col, input, 3 bits: asynchronous keypad column lines; 1 = key closed in the driven row.
REQ-006 SHALL have port row, output, 4 bits: one-hot row drive.
REQ-007 SHALL have port tenkey, output, 10 bits: one-hot digit 0..9, held while the key is accepted; feeds the lock controller's tenkey input.
REQ-008 SHALL have port close, output, 1 bit: held while '#' is accepted; feeds the lock controller's close input.

Function
REQ-009 SHALL use this keypad map, code = row*3+col: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#.
REQ-010 SHALL pass col through a 2-flop synchronizer before any use.
REQ-011 SHALL sample synchronized col once per row slot, in the last cycle of the slot; a sample is "single" when exactly one col bit is 1.
REQ-012 SHALL implement FSM states SCAN, DEB_PRESS, HELD and DEB_REL.
REQ-013 SCAN: advance row 0->1->2->3->0 every SCAN_DIV cycles; on a single sample, capture the code, clear the count, freeze row, and go to DEB_PRESS.
REQ-014 DEB_PRESS: row stays frozen; a sample equal to the captured column increments the count; any other sample (zero, multi, or different) returns to SCAN with row advancing normally.
REQ-015 DEB_PRESS->HELD SHALL occur when the count reaches DEBOUNCE; outputs assert in the cycle after that sample.
REQ-016 HELD: outputs are held; an all-zero sample goes to DEB_REL with the count set to 1.
REQ-017 DEB_REL: a zero sample increments the count and a nonzero sample returns to HELD; at count = DEBOUNCE, go to SCAN, with outputs deasserted in the cycle after that sample.
REQ-018 Outputs SHALL stay asserted through DEB_REL.
REQ-019 A digit key SHALL drive only tenkey[digit]=1; '#' SHALL drive only close=1; '*' SHALL be debounced but produce no output.
REQ-020 Multiple simultaneous keys in one row SHALL be ignored; keys in other rows SHALL be ignored while a row is frozen.
REQ-021 At most one of tenkey/close bits SHALL be 1 at any time; all outputs SHALL be registered.
REQ-022 The row slot counter SHALL be ceil(log2(SCAN_DIV)) bits and wrap to 0; the debounce counter SHALL be 4 bits and saturate at DEBOUNCE.

Reset
REQ-023 On reset=1 at a clock edge: state=SCAN, row=4'b0001, slot counter=0, debounce count=0, tenkey=0, close=0, synchronizer flops=0.
REQ-024 Reset mid-press SHALL clear outputs at that edge; a still-held key SHALL then be re-detected through the full debounce sequence.

Structure
REQ-025 Package tenkey_pkg SHALL hold the FSM state enum, the KEY_STAR/KEY_HASH code constants, and the code-to-digit map.
REQ-026 The synchronizer SHALL be a sub-module, tenkey_sync: 2-flop, 3 bits wide, reset to 0.

Verification
REQ-027 Check reset with col=0: row=0001, tenkey=0, close=0, and row rotating with period 16 cycles at the defaults.
REQ-028 Drive col[0]=1 only while row[2]=1, for 60 cycles, then release: tenkey=10'b0010000000 within 2+4+16+1 cycles of first sample; cleared 16 cycles after the first zero sample.
REQ-029 Hold key 1 for 2 samples, then release: tenkey stays 0 and row resumes rotating.
REQ-030 Press '#' for 60 cycles: close=1 and tenkey=0 throughout; then drive col=3'b011 on row0: no output.
REQ-031 Press key 5 to HELD and pulse one zero sample mid-hold: tenkey[5] stays 1 with no glitch.
REQ-032 Press key 9 to HELD, then assert reset for 1 cycle while still holding: outputs 0 at that edge, tenkey[9] reasserts after full debounce.

Source files
------------

// File: rtl/tenkey_pkg.sv
// tenkey_pkg: shared types, key codes and the keypad code-to-digit map for
// the ten-key scanner.
package tenkey_pkg;

    // Legacy state encodings. The enum below is built from them so older
    // scripts and waveform filters see the same values.
    localparam logic [1:0] S_SCAN      = 2'd0;
    localparam logic [1:0] S_DEB_PRESS = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_DEB_REL   = 2'd3;

    typedef enum logic [1:0] {
        ST_SCAN      = S_SCAN,
        ST_DEB_PRESS = S_DEB_PRESS,
        ST_HELD      = S_HELD,
        ST_DEB_REL   = S_DEB_REL
    } state_t;

    // Key codes are row*3+col. Codes 0..8 are digits 1..9; row 3 holds
    // '*', '0' and '#'.
    localparam logic [3:0] KEY_STAR = 4'd9;
    localparam logic [3:0] KEY_ZERO = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Registered output bundle handed to the lock controller.
    typedef struct packed {
        logic [9:0] tenkey;
        logic       close;
    } key_out_t;

    // Decoded digit for a key code; valid is low for '*' and '#'.
    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } digit_t;

    // Keypad map: key code to the digit it represents.
    function automatic digit_t code_to_digit(input logic [3:0] code);
        digit_t d;
        d = '0;
        case (code)
            4'd0:     d = '{valid: 1'b1, digit: 4'd1};
            4'd1:     d = '{valid: 1'b1, digit: 4'd2};
            4'd2:     d = '{valid: 1'b1, digit: 4'd3};
            4'd3:     d = '{valid: 1'b1, digit: 4'd4};
            4'd4:     d = '{valid: 1'b1, digit: 4'd5};
            4'd5:     d = '{valid: 1'b1, digit: 4'd6};
            4'd6:     d = '{valid: 1'b1, digit: 4'd7};
            4'd7:     d = '{valid: 1'b1, digit: 4'd8};
            4'd8:     d = '{valid: 1'b1, digit: 4'd9};
            KEY_ZERO: d = '{valid: 1'b1, digit: 4'd0};
            KEY_STAR: d = '0;
            KEY_HASH: d = '0;
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Output pattern for an accepted key: one-hot digit, or close for '#'.
    // '*' yields nothing, which keeps at most one output bit high.
    function automatic key_out_t code_to_out(input logic [3:0] code);
        key_out_t o;
        digit_t   d;
        o = '0;
        d = code_to_digit(code);
        if (d.valid) begin
            o.tenkey = 10'd1 << d.digit;
        end
        o.close = (code == KEY_HASH);
        return o;
    endfunction

    // True when exactly one column line is closed.
    function automatic logic is_single(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    // Column index of a one-hot column sample.
    function automatic logic [1:0] col_index(input logic [2:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        case (c)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Row index of the one-hot row drive.
    function automatic logic [1:0] row_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        case (r)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Key code from row and column indices.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return ({2'b00, r} * 4'd3) + {2'b00, c};
    endfunction

endpackage

// File: rtl/tenkey_sync.sv
// tenkey_sync: two-flop synchronizer for the asynchronous keypad column lines.
module tenkey_sync #(
    parameter int WIDTH = 3
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; reset clears both so no stale press survives it.
    always_ff @(posedge ck) begin
        // NOTE: non-blocking assignments keep these as two distinct stages; blocking ones would collapse them into one flop.
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tenkey_scan.sv
// tenkey_scan: 4x3 keypad scanner with press/release debounce. Drives one row
// at a time, samples the synchronized columns once per row slot, and holds a
// one-hot digit (or close for '#') while a key is accepted.
module tenkey_scan
    import tenkey_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [9:0] tenkey,
    output logic       close
);

    localparam int                SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        DEB_LIMIT = 4'(DEBOUNCE);

    logic [2:0]        col_s;
    logic [SLOT_W-1:0] slot_cnt;
    logic              tick;

    state_t     state;
    state_t     state_nx;
    logic [3:0] dcnt;
    logic [3:0] dcnt_nx;
    logic [3:0] dcnt_inc;
    logic [3:0] code;
    logic [3:0] code_nx;
    logic [2:0] cap_col;
    logic [2:0] cap_col_nx;
    logic [3:0] row_nx;
    key_out_t   out_q;
    key_out_t   out_nx;

    tenkey_sync #(
        .WIDTH(3)
    ) u_sync (
        .ck   (ck),
        .reset(reset),
        .d    (col),
        .q    (col_s)
    );

    // The column sample is taken in the last cycle of each row slot, which
    // gives the column lines the whole slot to settle after a row change.
    assign tick     = (slot_cnt == SLOT_LAST);
    assign dcnt_inc = dcnt + 4'd1;

    // Row slot counter: free-running, wraps to 0 after the last cycle.
    always_ff @(posedge ck) begin
        if (reset) begin
            slot_cnt <= '0;
        end else if (tick) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Next-state logic: all decisions happen on the slot's sample cycle.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned and no latch is inferred.
        state_nx   = state;
        dcnt_nx    = dcnt;
        code_nx    = code;
        cap_col_nx = cap_col;
        out_nx     = out_q;
        row_nx     = row;

        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (is_single(col_s)) begin
                        code_nx    = key_code(row_index(row), col_index(col_s));
                        cap_col_nx = col_s;
                        dcnt_nx    = 4'd0;
                        state_nx   = ST_DEB_PRESS;
                    end
                end

                ST_DEB_PRESS: begin
                    if (col_s == cap_col) begin
                        if (dcnt_inc == DEB_LIMIT) begin
                            dcnt_nx  = DEB_LIMIT;
                            out_nx   = code_to_out(code);
                            state_nx = ST_HELD;
                        end else begin
                            dcnt_nx = dcnt_inc;
                        end
                    end else begin
                        // Bounce, release or a second key: abandon this press.
                        state_nx = ST_SCAN;
                    end
                end

                ST_HELD: begin
                    if (col_s == 3'b000) begin
                        if (DEB_LIMIT == 4'd1) begin
                            // A single quiet sample already completes release.
                            dcnt_nx  = DEB_LIMIT;
                            out_nx   = '0;
                            state_nx = ST_SCAN;
                        end else begin
                            dcnt_nx  = 4'd1;
                            state_nx = ST_DEB_REL;
                        end
                    end
                end

                ST_DEB_REL: begin
                    if (col_s == 3'b000) begin
                        if (dcnt_inc == DEB_LIMIT) begin
                            dcnt_nx  = DEB_LIMIT;
                            out_nx   = '0;
                            state_nx = ST_SCAN;
                        end else begin
                            dcnt_nx = dcnt_inc;
                        end
                    end else begin
                        // Contact bounced closed again; the key is still held.
                        state_nx = ST_HELD;
                    end
                end

                default: begin
                    state_nx = ST_SCAN;
                end
            endcase

            // The row stays frozen on the pressed key's row for the whole
            // press/hold/release sequence and moves on only while scanning.
            if (state_nx == ST_SCAN) begin
                row_nx = {row[2:0], row[3]};
            end
        end
    end

    // FSM, row drive and output registers.
    always_ff @(posedge ck) begin
        if (reset) begin
            state   <= ST_SCAN;
            row     <= 4'b0001;
            dcnt    <= 4'd0;
            code    <= 4'd0;
            cap_col <= 3'b000;
            out_q   <= '0;
        end else begin
            state   <= state_nx;
            row     <= row_nx;
            dcnt    <= dcnt_nx;
            code    <= code_nx;
            cap_col <= cap_col_nx;
            out_q   <= out_nx;
        end
    end

    assign tenkey = out_q.tenkey;
    assign close  = out_q.close;

endmodule

// File: tb/tb_tenkey_scan.sv
// tb_tenkey_scan: directed and random keypad presses against a sample-level
// reference model of the scanner.
module tb_tenkey_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 4;

    logic        ck = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [9:0]  tenkey;
    logic        close;
    logic [11:0] keys = '0;   // pressed keys, indexed by code row*3+col

    int total = 0;
    int bad   = 0;

    // Reference model state, updated once per sample.
    int m_row    = 0;   // row index the scanner should be driving
    int cand     = -1;  // key code being confirmed, -1 when none
    int agree    = 0;   // agreeing samples since capture
    int accepted = -1;  // key code currently accepted, -1 when none
    int quiet    = 0;   // consecutive zero samples while accepted
    int cyc      = 0;   // clock edges since the last reset edge
    int abs_cyc  = 0;   // clock edges since time 0
    int cap_abs  = 0;   // abs_cyc of the latest capture sample
    int zero_abs = 0;   // abs_cyc of the latest first-zero sample while accepted

    tenkey_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .ck    (ck),
        .reset (reset),
        .col   (col),
        .row   (row),
        .tenkey(tenkey),
        .close (close)
    );

    always #5 ck = ~ck;

    // Keypad contacts: a closed key connects its row line to its column line.
    always_comb begin
        col = 3'b000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (row[r] && keys[r*3+c]) col[c] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row    = 0;
        cand     = -1;
        agree    = 0;
        accepted = -1;
        quiet    = 0;
        cyc      = 0;
    endtask

    // One sample of the keypad on the expected row, applied to the
    // press/accept/release rules.
    task automatic model_sample();
        logic [2:0] s;
        s = keys[m_row*3 +: 3];
        if (accepted >= 0) begin
            if (s == 3'b000) begin
                quiet++;
                if (quiet == 1) zero_abs = abs_cyc;
            end else begin
                quiet = 0;
            end
            if (quiet >= DEBOUNCE) begin
                accepted = -1;
                quiet    = 0;
                m_row    = (m_row + 1) % 4;
            end
        end else if (cand >= 0) begin
            if (s == 3'(1 << (cand % 3))) begin
                agree++;
                if (agree >= DEBOUNCE) begin
                    accepted = cand;
                    cand     = -1;
                    quiet    = 0;
                end
            end else begin
                cand  = -1;
                m_row = (m_row + 1) % 4;
            end
        end else if ($countones(s) == 1) begin
            cand    = m_row * 3 + (s[0] ? 0 : (s[1] ? 1 : 2));
            agree   = 0;
            cap_abs = abs_cyc;
        end else begin
            m_row = (m_row + 1) % 4;
        end
    endtask

    function automatic logic [9:0] exp_tenkey();
        logic [9:0] v;
        v = '0;
        if (accepted >= 0 && accepted <= 8) v[accepted+1] = 1'b1;
        else if (accepted == 10) v[0] = 1'b1;
        return v;
    endfunction

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic cycle();
        logic [3:0] er;
        @(posedge ck);
        abs_cyc++;
        if (reset) begin
            model_reset();
        end else begin
            cyc++;
            if (cyc % SCAN_DIV == 0) model_sample();
        end
        @(negedge ck);
        er = 4'b0001 << m_row;
        check("row", row, er);
        check("tenkey", tenkey, exp_tenkey());
        check("close", close, accepted == 11);
    endtask

    // One row slot; key changes happen only on slot boundaries.
    task automatic window(input int n);
        repeat (n * SCAN_DIV) cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int seen;
        int cnt;
        int a;
        int b;

        // Reset with the keypad idle, then watch the row rotate.
        keys = '0;
        do_reset(3);
        check("rst_row", row, 4'b0001);
        check("rst_tenkey", tenkey, 10'd0);
        check("rst_close", close, 1'b0);
        window(1);
        check("row_after_slot", row, 4'b0010);
        window(3);
        check("row_period16", row, 4'b0001);
        window(4);

        // Key 7 (row 2, col 0) held 60 cycles, then released.
        keys = 12'b1 << 6;
        seen = -1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (seen < 0 && tenkey === 10'b0010000000) seen = abs_cyc;
        end
        check("key7_seen", seen >= 0, 1'b1);
        check("key7_latency", (seen - cap_abs) <= 2 + 4 + 16 + 1, 1'b1);
        check("key7_held", tenkey, 10'b0010000000);
        keys = '0;
        seen = -1;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (seen < 0 && tenkey === 10'd0) seen = abs_cyc;
        end
        check("key7_cleared", seen >= 0, 1'b1);
        check("key7_release_lat", (seen - zero_abs) <= 16, 1'b1);

        // Key 1 seen for only two samples: no output, scanning resumes.
        window(2);
        for (int w = 0; w < 4 && m_row != 0; w++) window(1);
        keys = 12'b1;
        window(2);
        keys = '0;
        window(1);
        a = int'(row);
        window(1);
        check("short_row_moves", int'(row) != a, 1'b1);
        check("short_no_output", tenkey, 10'd0);
        window(4);

        // '#' held 60 cycles: close only.
        keys = 12'b1 << 11;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (close === 1'b1) cnt++;
        end
        check("hash_close_seen", cnt > 0, 1'b1);
        check("hash_close", close, 1'b1);
        check("hash_tenkey", tenkey, 10'd0);
        keys = '0;
        window(6);

        // Keys 1 and 2 together on row 0: ignored.
        keys = 12'b011;
        window(8);
        check("multi_tenkey", tenkey, 10'd0);
        check("multi_close", close, 1'b0);
        keys = '0;
        window(2);

        // Key 5 held, with one zero sample in the middle of the hold.
        keys = 12'b1 << 4;
        window(10);
        check("key5_held", tenkey, 10'b0000100000);
        keys = '0;
        cnt = 0;
        for (int i = 0; i < SCAN_DIV; i++) begin
            cycle();
            if (tenkey !== 10'b0000100000) cnt++;
        end
        keys = 12'b1 << 4;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            cycle();
            if (tenkey !== 10'b0000100000) cnt++;
        end
        check("key5_no_glitch", cnt, 0);
        keys = '0;
        window(6);

        // Key 9 held across a one-cycle reset.
        keys = 12'b1 << 8;
        window(10);
        check("key9_held", tenkey, 10'b1000000000);
        do_reset(1);
        check("key9_rst_clear", tenkey, 10'd0);
        check("key9_rst_row", row, 4'b0001);
        window(2);
        check("key9_redebounce_low", tenkey, 10'd0);
        window(8);
        check("key9_reasserted", tenkey, 10'b1000000000);
        keys = '0;
        window(6);

        // Random presses, bounces and chords.
        for (int w = 0; w < 300; w++) begin
            if ($urandom_range(99) >= 60) begin
                a = $urandom_range(99);
                if (a < 30) begin
                    keys = '0;
                end else if (a < 85) begin
                    keys = 12'b1 << $urandom_range(11);
                end else begin
                    a = $urandom_range(11);
                    b = $urandom_range(11);
                    keys = (12'b1 << a) | (12'b1 << b);
                end
            end
            window(1);
        end
        keys = '0;
        window(8);
        check("final_tenkey", tenkey, 10'd0);
        check("final_close", close, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
